// File: rtl/down_timer_if.sv
// Signal bundle for down_timer: load/decrement controls in, count and status out.
interface down_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             ld;
  logic             dec;
  logic             reload;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output data_in, ld, dec, reload,
    input  q, zero, tc, busy, done
  );

  modport slave (
    input  data_in, ld, dec, reload,
    output q, zero, tc, busy, done
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with a one-cycle terminal-count pulse and
// optional auto-reload for periodic ticks.
module down_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  down_timer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] rld_val_q;
  logic             tc_q;

  // COUNT is only entered with a non-zero value, so q==1 is the only expiry point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      rld_val_q <= '0;
      tc_q      <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (bus.ld) begin
        q_q       <= bus.data_in;
        rld_val_q <= bus.data_in;
        state_q   <= (bus.data_in != '0) ? COUNT : IDLE;
      end else if (state_q == COUNT && bus.dec) begin
        if (q_q > ONE) begin
          q_q <= q_q - ONE;
        end else begin
          tc_q <= 1'b1;
          if (bus.reload) begin
            q_q <= rld_val_q;
          end else begin
            q_q     <= '0;
            state_q <= EXPIRED;
          end
        end
      end
    end
  end

  assign bus.q    = q_q;
  assign bus.zero = (q_q == '0);
  assign bus.tc   = tc_q;
  assign bus.busy = (state_q == COUNT);
  assign bus.done = (state_q == EXPIRED);
endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: hand-computed step checks plus a per-cycle
// behavioural model compared on the falling edge.
module tb_down_timer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  down_timer_if #(.WIDTH(8)) bus ();

  down_timer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = counting, 2 = expired.
  logic [7:0] m_q   = 8'h00;
  logic [7:0] m_rld = 8'h00;
  logic       m_tc  = 1'b0;
  int         m_st  = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q = 8'h00; m_rld = 8'h00; m_tc = 1'b0; m_st = 0;
    end else begin
      m_tc = 1'b0;
      if (bus.ld) begin
        m_q   = bus.data_in;
        m_rld = bus.data_in;
        m_st  = (bus.data_in == 8'h00) ? 0 : 1;
      end else if (m_st == 1 && bus.dec) begin
        if (m_q == 8'h01) begin
          m_tc = 1'b1;
          if (bus.reload) m_q = m_rld;
          else begin m_q = 8'h00; m_st = 2; end
        end else begin
          m_q = m_q - 8'h01;
        end
      end
    end
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk8("model_q", bus.q, m_q);
    chk1("model_tc", bus.tc, m_tc);
    chk1("model_busy", bus.busy, m_st == 1);
    chk1("model_done", bus.done, m_st == 2);
    chk1("model_zero", bus.zero, m_q == 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic [7:0] eq, input logic etc,
                        input logic ebusy, input logic edone);
    chk8({tag, "_q"}, bus.q, eq);
    chk1({tag, "_tc"}, bus.tc, etc);
    chk1({tag, "_busy"}, bus.busy, ebusy);
    chk1({tag, "_done"}, bus.done, edone);
    chk1({tag, "_zero"}, bus.zero, eq == 8'h00);
  endtask

  logic [7:0] exp_q3  [6] = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h02};
  logic       exp_tc3 [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       dec4    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] exp_q4  [4] = '{8'h04, 8'h04, 8'h03, 8'h03};

  initial begin
    bus.data_in = 8'h00; bus.ld = 1'b0; bus.dec = 1'b0; bus.reload = 1'b0;
    tick(); tick();
    status("rst_hold", 8'h00, 1'b0, 1'b0, 1'b0);
    // ld/dec asserted during reset must be ignored
    bus.ld = 1'b1; bus.data_in = 8'h55; bus.dec = 1'b1;
    tick();
    status("rst_ignore", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.ld = 1'b0; bus.dec = 1'b0;
    #3 rst = 1'b1;

    // 1: asynchronous reset in the middle of a count at 0x23
    tick();
    bus.ld = 1'b1; bus.data_in = 8'h30;
    tick();
    status("t1_load", 8'h30, 1'b0, 1'b1, 1'b0);
    bus.ld = 1'b0; bus.dec = 1'b1;
    repeat (13) tick();
    status("t1_mid", 8'h23, 1'b0, 1'b1, 1'b0);
    bus.dec = 1'b0;
    #2 rst = 1'b0;
    #1 status("t1_async", 8'h00, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;

    // 2: one-shot expiry from 3
    tick();
    bus.ld = 1'b1; bus.data_in = 8'h03; bus.dec = 1'b1;
    tick();
    status("t2_q3", 8'h03, 1'b0, 1'b1, 1'b0);
    bus.ld = 1'b0;
    tick(); status("t2_q2", 8'h02, 1'b0, 1'b1, 1'b0);
    tick(); status("t2_q1", 8'h01, 1'b0, 1'b1, 1'b0);
    tick(); status("t2_q0", 8'h00, 1'b1, 1'b0, 1'b1);
    tick(); status("t2_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); status("t2_nowrap", 8'h00, 1'b0, 1'b0, 1'b1);

    // 3: periodic reload from 2
    bus.dec = 1'b0; bus.ld = 1'b1; bus.data_in = 8'h02; bus.reload = 1'b1;
    tick();
    status("t3_load", 8'h02, 1'b0, 1'b1, 1'b0);
    bus.ld = 1'b0; bus.dec = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      status("t3_cyc", exp_q3[i], exp_tc3[i], 1'b1, 1'b0);
    end
    bus.dec = 1'b0; bus.reload = 1'b0;

    // 4: intermittent decrement from 5
    bus.ld = 1'b1; bus.data_in = 8'h05;
    tick();
    bus.ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.dec = dec4[i];
      tick();
      status("t4_cyc", exp_q4[i], 1'b0, 1'b1, 1'b0);
    end

    // 5: load beats an expiring decrement at q==1
    bus.dec = 1'b1;
    tick(); tick();
    status("t5_pre", 8'h01, 1'b0, 1'b1, 1'b0);
    bus.ld = 1'b1; bus.data_in = 8'h80;
    tick();
    status("t5_ldwin", 8'h80, 1'b0, 1'b1, 1'b0);
    bus.ld = 1'b0; bus.dec = 1'b0;

    // 6: zero load goes idle and ignores dec
    bus.ld = 1'b1; bus.data_in = 8'h00;
    tick();
    status("t6_load0", 8'h00, 1'b0, 1'b0, 1'b0);
    bus.ld = 1'b0; bus.dec = 1'b1;
    repeat (3) tick();
    status("t6_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // reload value of 1: terminal count every decrement cycle
    bus.dec = 1'b0; bus.ld = 1'b1; bus.data_in = 8'h01; bus.reload = 1'b1;
    tick();
    status("r1_load", 8'h01, 1'b0, 1'b1, 1'b0);
    bus.ld = 1'b0; bus.dec = 1'b1;
    repeat (3) begin
      tick();
      status("r1_tick", 8'h01, 1'b1, 1'b1, 1'b0);
    end
    bus.dec = 1'b0; bus.reload = 1'b0;
    tick();
    status("r1_stop", 8'h01, 1'b0, 1'b1, 1'b0);

    // full-scale load
    bus.ld = 1'b1; bus.data_in = 8'hFF;
    tick();
    bus.ld = 1'b0; bus.dec = 1'b1;
    tick();
    status("max_dec", 8'hFE, 1'b0, 1'b1, 1'b0);
    bus.dec = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
